// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
//   lsu_state_t : access FSM states
//   F3_*        : RV32I load/store width field encodings
//   lsu_err_t   : access classification produced by the lane/check logic
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_ILLEGAL  = 2'd2,
    ERR_BUS      = 2'd3
  } lsu_err_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the load/store unit.
//   is_store, funct3, addr_lo : access descriptor (addr_lo = addr[1:0])
//   wdata                     : store data before lane steering
//   rdata                     : raw word from memory
//   be, wdata_lane            : byte enables and lane-replicated store data
//   load_data                 : selected and sign/zero-extended load result
//   err                       : ERR_ILLEGAL for bad funct3, ERR_MISALIGN for bad address
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] load_data,
  output lsu_err_t    err
);

  logic [31:0] shifted;

  always_comb begin
    be         = '0;
    wdata_lane = wdata;
    load_data  = rdata;
    err        = ERR_NONE;
    // bring the addressed byte/halfword down to bit 0
    shifted    = rdata >> {addr_lo, 3'b000};
    case (funct3)
      F3_B: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        load_data  = {{24{shifted[7]}}, shifted[7:0]};
      end
      F3_BU: begin
        be        = 4'b0001 << addr_lo;
        load_data = {24'd0, shifted[7:0]};
        if (is_store) err = ERR_ILLEGAL;
      end
      F3_H: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        load_data  = {{16{shifted[15]}}, shifted[15:0]};
        if (addr_lo[0]) err = ERR_MISALIGN;
      end
      F3_HU: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        load_data = {16'd0, shifted[15:0]};
        if (is_store)        err = ERR_ILLEGAL;
        else if (addr_lo[0]) err = ERR_MISALIGN;
      end
      F3_W: begin
        be = 4'b1111;
        if (addr_lo != 2'b00) err = ERR_MISALIGN;
      end
      default: err = ERR_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle data-memory access stage behind the ALU.
//   clk, rst (active-low, async)   : clock / reset
//   req_valid, is_store, funct3,
//   addr, wdata                    : instruction-side access request
//   stall, done, rdata,
//   misaligned, bus_err            : core-side status / load result
//   mem_req, mem_we, mem_addr,
//   mem_be, mem_wdata, mem_gnt,
//   mem_rvalid, mem_rdata          : request/grant/response memory bus
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  misaligned,
  output logic                  bus_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  lsu_state_t            state_q, state_d;
  logic                  is_store_q, mis_q, berr_q;
  logic [2:0]            funct3_q;
  logic [DATA_WIDTH-1:0] addr_q, wdata_q, rdata_q;
  logic [CW-1:0]         cnt_q;

  logic                  idle, timeout;
  logic                  a_is_store;
  logic [2:0]            a_funct3;
  logic [1:0]            a_addr_lo;
  logic [3:0]            be_w;
  logic [DATA_WIDTH-1:0] wd_w, ld_w;
  lsu_err_t              err_w;

  assign idle = (state_q == IDLE);
  // budget is shared by REQ and WAIT; >= covers a grant landing on the last REQ cycle
  assign timeout = (cnt_q >= CW'(TIMEOUT - 1));

  // In IDLE the checker looks at the live request so the decision is made
  // in the capture cycle; afterwards everything runs from the captured copy.
  assign a_is_store = idle ? is_store   : is_store_q;
  assign a_funct3   = idle ? funct3     : funct3_q;
  assign a_addr_lo  = idle ? addr[1:0]  : addr_q[1:0];

  lsu_align u_align (
    .is_store   (a_is_store),
    .funct3     (a_funct3),
    .addr_lo    (a_addr_lo),
    .wdata      (wdata_q),
    .rdata      (mem_rdata),
    .be         (be_w),
    .wdata_lane (wd_w),
    .load_data  (ld_w),
    .err        (err_w)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) state_d = (err_w != ERR_NONE) ? DONE : REQ;
      REQ: begin
        if (mem_gnt)      state_d = is_store_q ? DONE : WAIT;
        else if (timeout) state_d = DONE;
      end
      WAIT: if (mem_rvalid || timeout) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_store_q <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      mis_q      <= 1'b0;
      berr_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          is_store_q <= is_store;
          funct3_q   <= funct3;
          addr_q     <= addr;
          wdata_q    <= wdata;
          mis_q      <= (err_w != ERR_NONE);
          berr_q     <= 1'b0;
          cnt_q      <= '0;
        end
        REQ: begin
          cnt_q <= cnt_q + 1'b1;
          if (!mem_gnt && timeout) begin
            berr_q  <= 1'b1;
            rdata_q <= '0;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (mem_rvalid) rdata_q <= ld_w;
          else if (timeout) begin
            berr_q  <= 1'b1;
            rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // rst gates stall so a held req_valid cannot raise it during reset
  assign stall      = rst && ((idle && req_valid) || state_q == REQ || state_q == WAIT);
  assign done       = (state_q == DONE);
  assign misaligned = done & mis_q;
  assign bus_err    = done & berr_q;
  assign rdata      = rdata_q;

  // bus fields are only driven while requesting, so they are 0 otherwise
  assign mem_req   = (state_q == REQ);
  assign mem_we    = mem_req & is_store_q;
  assign mem_addr  = mem_req ? {addr_q[DATA_WIDTH-1:2], 2'b00} : '0;
  assign mem_be    = mem_req ? be_w : '0;
  assign mem_wdata = mem_req ? wd_w : '0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, done, misaligned, bus_err;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  // second instance with a short timeout
  logic        req_valid2, gnt2, rvalid2;
  logic        t_stall, t_done, t_mis, t_berr, t_mem_req, t_mem_we;
  logic [31:0] t_rdata, t_mem_addr, t_mem_wdata;
  logic [3:0]  t_mem_be;

  int checks = 0;
  int errors = 0;

  // results recorded by run_access
  int          r_lat, r_req_cycles;
  logic        r_saw_req, r_stable, r_stall_ok, r_done_stall, r_we, r_mis, r_berr;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_be;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .stall(stall), .done(done), .rdata(rdata),
    .misaligned(misaligned), .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  load_store_unit #(.TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .stall(t_stall), .done(t_done), .rdata(t_rdata),
    .misaligned(t_mis), .bus_err(t_berr), .mem_req(t_mem_req), .mem_we(t_mem_we),
    .mem_addr(t_mem_addr), .mem_be(t_mem_be), .mem_wdata(t_mem_wdata), .mem_gnt(gnt2),
    .mem_rvalid(rvalid2), .mem_rdata(mem_rdata)
  );

  // Drives one access on dut from IDLE through DONE. gnt_dly = number of REQ
  // cycles without grant (-1 = never). Cycle 1 is the req_valid cycle.
  task automatic run_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rd, input int gnt_dly);
    int  gcnt;
    logic pend_rv;
    gcnt = 0; pend_rv = 0;
    r_lat = 0; r_req_cycles = 0; r_saw_req = 0; r_stable = 1; r_stall_ok = 1;
    r_done_stall = 1'bx; r_mis = 1'bx; r_berr = 1'bx; r_rdata = 'x;
    @(negedge clk);
    req_valid = 1; is_store = st; funct3 = f3; addr = a; wdata = wd; mem_rdata = rd;
    for (int c = 1; c <= 40; c++) begin
      #1;
      if (done) begin
        r_lat = c; r_rdata = rdata; r_mis = misaligned; r_berr = bus_err; r_done_stall = stall;
        break;
      end
      if (stall !== 1'b1) r_stall_ok = 0;
      mem_gnt = 0; mem_rvalid = 0;
      if (mem_req) begin
        if (!r_saw_req) begin
          r_addr = mem_addr; r_be = mem_be; r_we = mem_we; r_wdata = mem_wdata;
        end else if (mem_addr !== r_addr || mem_be !== r_be || mem_we !== r_we || mem_wdata !== r_wdata)
          r_stable = 0;
        r_saw_req = 1; r_req_cycles++;
      end
      if (pend_rv) begin
        mem_rvalid = 1; pend_rv = 0;
      end else if (mem_req) begin
        if (gcnt == gnt_dly) begin
          mem_gnt = 1;
          if (!st) pend_rv = 1;
        end
        gcnt++;
      end
      @(negedge clk);
    end
    req_valid = 0; mem_gnt = 0; mem_rvalid = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 0; req_valid = 0; req_valid2 = 0; is_store = 0; funct3 = 0; addr = 0; wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; gnt2 = 0; rvalid2 = 0;
    repeat (2) @(negedge clk);
    #1;
    if ({stall, done, misaligned, bus_err, mem_req, mem_we} !== 6'b0) begin
      errors++; $display("FAIL reset_ctl got %b exp 000000", {stall, done, misaligned, bus_err, mem_req, mem_we});
    end
    checks++;
    if ({rdata, mem_addr, mem_wdata, mem_be} !== 100'd0) begin
      errors++; $display("FAIL reset_data rdata %h addr %h wdata %h be %h exp all 0", rdata, mem_addr, mem_wdata, mem_be);
    end
    checks++;
    rst = 1;
    @(negedge clk);
  endtask

  task automatic test_lw();
    run_access(0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    if (r_lat !== 4) begin errors++; $display("FAIL lw_latency got %0d exp 4", r_lat); end
    checks++;
    if (r_addr !== 32'h100 || r_be !== 4'hF || r_we !== 1'b0) begin
      errors++; $display("FAIL lw_bus addr %h be %h we %b exp 00000100 f 0", r_addr, r_be, r_we);
    end
    checks++;
    if (r_rdata !== 32'hDEADBEEF || r_mis !== 0 || r_berr !== 0) begin
      errors++; $display("FAIL lw_data rdata %h mis %b berr %b exp deadbeef 0 0", r_rdata, r_mis, r_berr);
    end
    checks++;
    if (r_stall_ok !== 1 || r_done_stall !== 0) begin
      errors++; $display("FAIL lw_stall busy %b done_stall %b exp 1 0", r_stall_ok, r_done_stall);
    end
    checks++;
  endtask

  task automatic test_sub_word_loads();
    run_access(0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0);
    if (r_rdata !== 32'hFFFFFF80 || r_be !== 4'b1000 || r_addr !== 32'h100) begin
      errors++; $display("FAIL lb rdata %h be %h addr %h exp ffffff80 8 00000100", r_rdata, r_be, r_addr);
    end
    checks++;
    run_access(0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 0);
    if (r_rdata !== 32'h00000080) begin errors++; $display("FAIL lbu rdata %h exp 00000080", r_rdata); end
    checks++;
    run_access(0, 3'b001, 32'h102, 32'h0, 32'h80FF1234, 0);
    if (r_rdata !== 32'hFFFF80FF || r_be !== 4'b1100) begin
      errors++; $display("FAIL lh rdata %h be %h exp ffff80ff c", r_rdata, r_be);
    end
    checks++;
    run_access(0, 3'b101, 32'h100, 32'h0, 32'hFEDC8765, 0);
    if (r_rdata !== 32'h00008765 || r_be !== 4'b0011) begin
      errors++; $display("FAIL lhu rdata %h be %h exp 00008765 3", r_rdata, r_be);
    end
    checks++;
  endtask

  task automatic test_stores();
    run_access(1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 0);
    if (r_lat !== 3) begin errors++; $display("FAIL sh_latency got %0d exp 3", r_lat); end
    checks++;
    if (r_we !== 1 || r_be !== 4'b1100 || r_wdata !== 32'hABCDABCD || r_addr !== 32'h200) begin
      errors++; $display("FAIL sh_bus we %b be %h wdata %h addr %h exp 1 c abcdabcd 00000200", r_we, r_be, r_wdata, r_addr);
    end
    checks++;
    run_access(1, 3'b000, 32'h201, 32'h11223355, 32'h0, 0);
    if (r_be !== 4'b0010 || r_wdata !== 32'h55555555) begin
      errors++; $display("FAIL sb_bus be %h wdata %h exp 2 55555555", r_be, r_wdata);
    end
    checks++;
    run_access(1, 3'b010, 32'h204, 32'h12345678, 32'h0, 0);
    if (r_be !== 4'hF || r_wdata !== 32'h12345678 || r_addr !== 32'h204) begin
      errors++; $display("FAIL sw_bus be %h wdata %h addr %h exp f 12345678 00000204", r_be, r_wdata, r_addr);
    end
    checks++;
  endtask

  task automatic test_misaligned();
    run_access(0, 3'b010, 32'h101, 32'h0, 32'h0, 0);
    if (r_lat !== 2 || r_mis !== 1 || r_saw_req !== 0) begin
      errors++; $display("FAIL lw_misaligned lat %0d mis %b req %b exp 2 1 0", r_lat, r_mis, r_saw_req);
    end
    checks++;
    run_access(1, 3'b001, 32'h203, 32'h0, 32'h0, 0);
    if (r_lat !== 2 || r_mis !== 1 || r_saw_req !== 0) begin
      errors++; $display("FAIL sh_misaligned lat %0d mis %b req %b exp 2 1 0", r_lat, r_mis, r_saw_req);
    end
    checks++;
    run_access(0, 3'b011, 32'h100, 32'h0, 32'h0, 0);
    if (r_lat !== 2 || r_mis !== 1 || r_saw_req !== 0) begin
      errors++; $display("FAIL load_f3_011 lat %0d mis %b req %b exp 2 1 0", r_lat, r_mis, r_saw_req);
    end
    checks++;
    run_access(1, 3'b100, 32'h100, 32'h0, 32'h0, 0);
    if (r_lat !== 2 || r_mis !== 1 || r_saw_req !== 0) begin
      errors++; $display("FAIL store_f3_100 lat %0d mis %b req %b exp 2 1 0", r_lat, r_mis, r_saw_req);
    end
    checks++;
  endtask

  task automatic test_gnt_delay();
    run_access(0, 3'b010, 32'h300, 32'h0, 32'hA5A5_0F0F, 3);
    if (r_req_cycles !== 4 || r_stable !== 1 || r_stall_ok !== 1) begin
      errors++; $display("FAIL gnt_delay req_cycles %0d stable %b stall %b exp 4 1 1", r_req_cycles, r_stable, r_stall_ok);
    end
    checks++;
    if (r_lat !== 7 || r_rdata !== 32'hA5A50F0F || r_berr !== 0) begin
      errors++; $display("FAIL gnt_delay_result lat %0d rdata %h berr %b exp 7 a5a50f0f 0", r_lat, r_rdata, r_berr);
    end
    checks++;
  endtask

  task automatic test_timeout();
    int lat, nreq;
    // a good load first so rdata=0 afterwards really comes from the abort
    @(negedge clk);
    req_valid2 = 1; is_store = 0; funct3 = 3'b010; addr = 32'h300; mem_rdata = 32'h12345678;
    @(negedge clk); gnt2 = 1;
    @(negedge clk); gnt2 = 0; rvalid2 = 1;
    @(negedge clk); rvalid2 = 0; #1;
    if (t_done !== 1 || t_rdata !== 32'h12345678) begin
      errors++; $display("FAIL to_warmup done %b rdata %h exp 1 12345678", t_done, t_rdata);
    end
    checks++;
    req_valid2 = 0;
    @(negedge clk);
    req_valid2 = 1; lat = 0; nreq = 0;
    for (int c = 1; c <= 20; c++) begin
      #1;
      if (t_done) begin lat = c; break; end
      if (t_mem_req) nreq++;
      @(negedge clk);
    end
    if (lat !== 6 || nreq !== 4) begin
      errors++; $display("FAIL timeout_latency lat %0d req_cycles %0d exp 6 4", lat, nreq);
    end
    checks++;
    if (t_berr !== 1 || t_rdata !== 32'h0 || t_mem_req !== 0 || t_mis !== 0) begin
      errors++; $display("FAIL timeout_result berr %b rdata %h req %b mis %b exp 1 0 0 0", t_berr, t_rdata, t_mem_req, t_mis);
    end
    checks++;
    req_valid2 = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    // reset during REQ: mem_req must fall without a clock edge
    @(negedge clk);
    req_valid = 1; is_store = 0; funct3 = 3'b010; addr = 32'h400; mem_rdata = 32'h0;
    @(negedge clk); #1;
    if (mem_req !== 1) begin errors++; $display("FAIL rst_req_pre mem_req %b exp 1", mem_req); end
    checks++;
    rst = 0; #1;
    if (mem_req !== 0 || stall !== 0) begin
      errors++; $display("FAIL rst_in_req mem_req %b stall %b exp 0 0", mem_req, stall);
    end
    checks++;
    @(negedge clk); rst = 1;
    // reset during WAIT
    @(negedge clk); #1;
    mem_gnt = 1;
    @(negedge clk); mem_gnt = 0; #1;
    if (stall !== 1 || mem_req !== 0) begin
      errors++; $display("FAIL rst_wait_pre stall %b mem_req %b exp 1 0", stall, mem_req);
    end
    checks++;
    rst = 0; #1;
    if (mem_req !== 0 || stall !== 0 || done !== 0) begin
      errors++; $display("FAIL rst_in_wait req %b stall %b done %b exp 0 0 0", mem_req, stall, done);
    end
    checks++;
    req_valid = 0;
    @(negedge clk); rst = 1; mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk); mem_rvalid = 0; #1;
    if (done !== 0 || stall !== 0 || rdata !== 32'h0) begin
      errors++; $display("FAIL late_rvalid done %b stall %b rdata %h exp 0 0 0", done, stall, rdata);
    end
    checks++;
    run_access(0, 3'b010, 32'h104, 32'h0, 32'h0BADCAFE, 0);
    if (r_lat !== 4 || r_rdata !== 32'h0BADCAFE || r_addr !== 32'h104) begin
      errors++; $display("FAIL post_reset_lw lat %0d rdata %h addr %h exp 4 0badcafe 00000104", r_lat, r_rdata, r_addr);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sub_word_loads();
    test_stores();
    test_misaligned();
    test_gnt_delay();
    test_timeout();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
